// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : Parametrised register file with one write port and two
//               independent registered read ports (1-cycle latency,
//               write-first bypass), plus a sequential clear engine that
//               zeroes one entry per clock.
// Optional    : `define RF_PARITY_EN adds a per-entry even-parity bit,
//               an error-injection input and per-port parity-error flags.
// Ports       : clk, reset_n         - clock / async active-low reset
//               we, wAddr, wData     - write port
//               re_a, rAddr_a        - read request / address, port A
//               rData_a, rvalid_a    - registered read data / valid, port A
//               re_b, rAddr_b        - read request / address, port B
//               rData_b, rvalid_b    - registered read data / valid, port B
//               clr_req              - start array clear (level-sampled)
//               busy                 - clear in progress
//               clr_done             - one-cycle pulse at clear completion
//               inj_perr             - (parity) invert stored parity on write
//               perr_a, perr_b       - (parity) registered parity mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] rAddr_a,
    output logic [DATA_W-1:0] rData_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] rAddr_b,
    output logic [DATA_W-1:0] rData_b,
    output logic              rvalid_b,
`ifdef RF_PARITY_EN
    input  logic              inj_perr,
    output logic              perr_a,
    output logic              perr_b,
`endif
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    // Widened by one bit so the range check works even when 2**ADDR_W == DEPTH.
    localparam logic [ADDR_W:0]   c_DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH-1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_clr_done, w_clr_done_nxt;

    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic                w_wr_ok;
    logic                w_clr_wr;

    logic [DATA_W-1:0]   r_rdata_a, r_rdata_b;
    logic                r_rvalid_a, r_rvalid_b;
    logic [DATA_W-1:0]   w_rd_a, w_rd_b;
    logic                w_pe_a, w_pe_b;

    // Writes are only honoured outside a clear and inside the array.
    assign w_wr_ok  = we && !r_busy && ({1'b0, wAddr} < c_DEPTH_X);
    assign w_clr_wr = (r_state == S_CLEAR);

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= w_busy_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_busy_nxt     = r_busy;
        w_clr_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_CLEAR: begin
                // The entry at r_ptr is zeroed on this same edge.
                if (r_ptr == c_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_ptr_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_clr_done_nxt = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_wr) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wAddr] <= wData;
        end
    end

`ifdef RF_PARITY_EN
    logic r_par [0:DEPTH-1];
    logic w_wpar;
    logic r_perr_a, r_perr_b;

    assign w_wpar = (^wData) ^ inj_perr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_par[i] <= 1'b0;
            end
        end else if (w_clr_wr) begin
            r_par[r_ptr] <= 1'b0;
        end else if (w_wr_ok) begin
            r_par[wAddr] <= w_wpar;
        end
    end

    assign perr_a = r_perr_a;
    assign perr_b = r_perr_b;
`endif

    // ------------------------------------------------------------------
    // Read-data selection. Priority: out-of-range -> 0, same-cycle write
    // (write-first), entry being cleared -> 0, then stored contents.
    // Bypassed and cleared values carry fresh parity, so no error flag.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_a = '0;
        w_pe_a = 1'b0;
        if ({1'b0, rAddr_a} < c_DEPTH_X) begin
            if (w_wr_ok && (wAddr == rAddr_a)) begin
                w_rd_a = wData;
            end else if (w_clr_wr && (r_ptr == rAddr_a)) begin
                w_rd_a = '0;
            end else begin
                w_rd_a = r_mem[rAddr_a];
`ifdef RF_PARITY_EN
                w_pe_a = (^r_mem[rAddr_a]) ^ r_par[rAddr_a];
`endif
            end
        end
    end

    always_comb begin
        w_rd_b = '0;
        w_pe_b = 1'b0;
        if ({1'b0, rAddr_b} < c_DEPTH_X) begin
            if (w_wr_ok && (wAddr == rAddr_b)) begin
                w_rd_b = wData;
            end else if (w_clr_wr && (r_ptr == rAddr_b)) begin
                w_rd_b = '0;
            end else begin
                w_rd_b = r_mem[rAddr_b];
`ifdef RF_PARITY_EN
                w_pe_b = (^r_mem[rAddr_b]) ^ r_par[rAddr_b];
`endif
            end
        end
    end

    // Read output registers: data holds when no request, valid drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata_a  <= '0;
            r_rvalid_a <= 1'b0;
            r_rdata_b  <= '0;
            r_rvalid_b <= 1'b0;
`ifdef RF_PARITY_EN
            r_perr_a   <= 1'b0;
            r_perr_b   <= 1'b0;
`endif
        end else begin
            r_rvalid_a <= re_a;
            r_rvalid_b <= re_b;
            if (re_a) begin
                r_rdata_a <= w_rd_a;
`ifdef RF_PARITY_EN
                r_perr_a  <= w_pe_a;
`endif
            end
            if (re_b) begin
                r_rdata_b <= w_rd_b;
`ifdef RF_PARITY_EN
                r_perr_b  <= w_pe_b;
`endif
            end
        end
    end

`ifndef RF_PARITY_EN
    // Parity flags are computed unconditionally but only consumed with parity on.
    logic w_unused_pe;
    assign w_unused_pe = w_pe_a ^ w_pe_b;
`endif

    assign rData_a  = r_rdata_a;
    assign rvalid_a = r_rvalid_a;
    assign rData_b  = r_rdata_b;
    assign rvalid_b = r_rvalid_b;
    assign busy     = r_busy;
    assign clr_done = r_clr_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Directed self-checking bench for reg_file_2r1w (default
//               8 x 32 configuration; parity steps when RF_PARITY_EN is set).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        re_a, re_b;
    logic [2:0]  rAddr_a, rAddr_b;
    logic [31:0] rData_a, rData_b;
    logic        rvalid_a, rvalid_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
`ifdef RF_PARITY_EN
    logic        inj_perr;
    logic        perr_a, perr_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    reg_file_2r1w #(.DATA_W(32), .DEPTH(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (we),
        .wAddr    (wAddr),
        .wData    (wData),
        .re_a     (re_a),
        .rAddr_a  (rAddr_a),
        .rData_a  (rData_a),
        .rvalid_a (rvalid_a),
        .re_b     (re_b),
        .rAddr_b  (rAddr_b),
        .rData_b  (rData_b),
        .rvalid_b (rvalid_b),
`ifdef RF_PARITY_EN
        .inj_perr (inj_perr),
        .perr_a   (perr_a),
        .perr_b   (perr_b),
`endif
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; wAddr = a; wData = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd2(input logic [2:0] aa, input logic [2:0] ab);
        re_a = 1'b1; rAddr_a = aa;
        re_b = 1'b1; rAddr_b = ab;
        tick();
        re_a = 1'b0; re_b = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; wAddr = '0; wData = '0;
        re_a = 1'b0; re_b = 1'b0; rAddr_a = '0; rAddr_b = '0; clr_req = 1'b0;
`ifdef RF_PARITY_EN
        inj_perr = 1'b0;
`endif
        #12;
        // Reset state
        chk("rst_rData_a", rData_a, 32'h0);
        chk("rst_rData_b", rData_b, 32'h0);
        chk("rst_rvalid_a", {31'h0, rvalid_a}, 32'h0);
        chk("rst_rvalid_b", {31'h0, rvalid_b}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_clr_done", {31'h0, clr_done}, 32'h0);
`ifdef RF_PARITY_EN
        chk("rst_perr", {30'h0, perr_a, perr_b}, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // All entries read zero on both ports, valid one cycle after request
        for (int i = 0; i < 8; i++) begin
            rd2(3'(i), 3'(7 - i));
            chk("init_rd_a", rData_a, 32'h0);
            chk("init_rd_b", rData_b, 32'h0);
            chk("init_valid", {30'h0, rvalid_a, rvalid_b}, 32'h3);
        end
        tick();
        chk("valid_drop", {30'h0, rvalid_a, rvalid_b}, 32'h0);

        // Write then read same address on both ports
        wr(3'd3, 32'hDEADBEEF);
        rd2(3'd3, 3'd3);
        chk("wr3_rd_a", rData_a, 32'hDEADBEEF);
        chk("wr3_rd_b", rData_b, 32'hDEADBEEF);

        // Same-cycle write bypass on A, untouched entry on B
        we = 1'b1; wAddr = 3'd5; wData = 32'h12345678;
        re_a = 1'b1; rAddr_a = 3'd5;
        re_b = 1'b1; rAddr_b = 3'd4;
        tick();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
        chk("bypass_a", rData_a, 32'h12345678);
        chk("old_b", rData_b, 32'h0);
        tick();
        chk("hold_a", rData_a, 32'h12345678);
        chk("hold_valid_a", {31'h0, rvalid_a}, 32'h0);
        rd2(3'd5, 3'd3);
        chk("stored5_a", rData_a, 32'h12345678);
        chk("stored3_b", rData_b, 32'hDEADBEEF);

        // Fill, then clear
        for (int i = 0; i < 8; i++) wr(3'(i), 32'hA5A5A5A5);
        clr_req = 1'b1;
        tick();                                   // E0: clear accepted
        clr_req = 1'b0;
        chk("clr_busy_e0", {31'h0, busy}, 32'h1);
        chk("clr_done_e0", {31'h0, clr_done}, 32'h0);
        tick();                                   // E1: entry 0 zeroed
        chk("clr_busy_e1", {31'h0, busy}, 32'h1);
        wr(3'd0, 32'hFFFFFFFF);                   // E2: dropped, entry 1 zeroed
        chk("clr_busy_e2", {31'h0, busy}, 32'h1);
        rd2(3'd2, 3'd5);                          // E3: entry 2 zeroed now
        chk("clr_rd_ptr_a", rData_a, 32'h0);
        chk("clr_rd_old_b", rData_b, 32'hA5A5A5A5);
        chk("clr_busy_e3", {31'h0, busy}, 32'h1);
        for (int k = 4; k < 8; k++) begin
            tick();
            chk("clr_busy_mid", {31'h0, busy}, 32'h1);
            chk("clr_done_mid", {31'h0, clr_done}, 32'h0);
        end
        tick();                                   // E8: entry 7 zeroed, done
        chk("clr_busy_e8", {31'h0, busy}, 32'h0);
        chk("clr_done_e8", {31'h0, clr_done}, 32'h1);
        tick();
        chk("clr_done_e9", {31'h0, clr_done}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd2(3'(i), 3'(i));
            chk("post_clr_a", rData_a, 32'h0);
            chk("post_clr_b", rData_b, 32'h0);
        end

        // Reset mid-clear
        wr(3'd7, 32'hA5A5A5A5);
        wr(3'd1, 32'h5A5A5A5A);
        clr_req = 1'b1;
        tick();                                   // E0
        clr_req = 1'b0;
        tick();
        tick();
        tick();                                   // ptr now 3, entry 7 still set
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, clr_done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("midrst_no_done", {30'h0, busy, clr_done}, 32'h0);
        end
        rd2(3'd7, 3'd1);
        chk("midrst_zero7", rData_a, 32'h0);
        chk("midrst_zero1", rData_b, 32'h0);
        wr(3'd6, 32'h0BADF00D);
        rd2(3'd6, 3'd6);
        chk("post_rst_wr_a", rData_a, 32'h0BADF00D);
        chk("post_rst_wr_b", rData_b, 32'h0BADF00D);

        // clr_req held through completion restarts the clear
        clr_req = 1'b1;
        for (int k = 0; k < 8; k++) tick();       // E0..E7
        chk("hold_busy", {31'h0, busy}, 32'h1);
        tick();                                   // E8: done, clr_req resampled
        chk("hold_done", {31'h0, clr_done}, 32'h1);
        chk("hold_busy_e8", {31'h0, busy}, 32'h0);
        tick();                                   // E9: restart
        clr_req = 1'b0;
        chk("restart_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 8; k++) tick();
        chk("restart_end", {30'h0, busy, clr_done}, 32'h1);
        tick();

`ifdef RF_PARITY_EN
        inj_perr = 1'b1;
        wr(3'd2, 32'h00000001);
        inj_perr = 1'b0;
        rd2(3'd2, 3'd3);
        chk("perr_inj_a", {31'h0, perr_a}, 32'h1);
        chk("perr_clean_b", {31'h0, perr_b}, 32'h0);
        wr(3'd2, 32'h00000001);
        rd2(3'd2, 3'd2);
        chk("perr_fixed_a", {31'h0, perr_a}, 32'h0);
        chk("perr_data_a", rData_a, 32'h00000001);
        inj_perr = 1'b1;
        we = 1'b1; wAddr = 3'd4; wData = 32'h7; re_a = 1'b1; rAddr_a = 3'd4;
        tick();
        we = 1'b0; re_a = 1'b0; inj_perr = 1'b0;
        chk("perr_bypass_a", {31'h0, perr_a}, 32'h0);
        rd2(3'd4, 3'd4);
        chk("perr_stored_b", {31'h0, perr_b}, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
